// File: rtl/ball_motion.sv
// ball_motion: ball-motion engine for the brick-breaker playfield.
// Parks the ball on the paddle until served, then moves it one pixel per axis
// on every step tick. Reflects off the side walls, the top wall and the paddle,
// detects misses, and keeps the lives count and the game-over flag.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-low reset
//   start      game-run enable; 0 freezes motion and the step timer
//   serve_n    serve button, active-low
//   paddle_x   paddle left x from the paddle block
//   ball_x/y   ball top-left corner
//   dir_x      1=right, 0=left
//   dir_y      1=down, 0=up
//   state      0=PARK, 1=MOVE, 2=MISS, 3=OVER
//   paddle_hit one-cycle pulse on paddle bounce
//   miss       one-cycle pulse while the lost ball is being accounted
//   lives      remaining lives
//   game_over  high in OVER
//
// state | meaning
// PARK  | ball rides on the paddle, waiting for a serve
// MOVE  | ball in flight, stepped on each tick
// MISS  | one cycle: ball lost, lives decremented
// OVER  | no lives left, frozen until reset
module ball_motion #(
   parameter int X_MIN       = 134,
   parameter int X_MAX       = 506,
   parameter int Y_MIN       = 40,
   parameter int Y_MAX       = 470,
   parameter int PADDLE_W    = 62,
   parameter int PADDLE_Y    = 440,
   parameter int PADDLE_X0   = 290,
   parameter int BALL_SIZE   = 8,
   parameter int STEP_CYCLES = 250000,
   parameter int LIVES       = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       serve_n,
   input  logic [8:0] paddle_x,
   output logic [8:0] ball_x,
   output logic [8:0] ball_y,
   output logic       dir_x,
   output logic       dir_y,
   output logic [1:0] state,
   output logic       paddle_hit,
   output logic       miss,
   output logic [1:0] lives,
   output logic       game_over
);

   typedef enum logic [1:0] {
      PARK = 2'd0,
      MOVE = 2'd1,
      MISS = 2'd2,
      OVER = 2'd3
   } state_t;

   localparam int               CNT_W    = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);
   localparam logic [9:0]       PARK_OFF = 10'(PADDLE_W / 2 - BALL_SIZE / 2);
   localparam logic [8:0]       PARK_Y   = 9'(PADDLE_Y - BALL_SIZE);
   localparam logic [8:0]       RST_X    = 9'(PADDLE_X0 + PADDLE_W / 2 - BALL_SIZE / 2);
   localparam logic [9:0]       BALL10   = 10'(BALL_SIZE);
   localparam logic [9:0]       PW10     = 10'(PADDLE_W);
   localparam logic [9:0]       XMIN10   = 10'(X_MIN);
   localparam logic [9:0]       XMAX10   = 10'(X_MAX);
   localparam logic [9:0]       YMIN10   = 10'(Y_MIN);
   localparam logic [9:0]       YMAX10   = 10'(Y_MAX);
   localparam logic [9:0]       PY10     = 10'(PADDLE_Y);

   state_t           state_q, state_d;
   logic [8:0]       ball_x_q, ball_x_d, ball_y_q, ball_y_d;
   logic             dir_x_q, dir_x_d, dir_y_q, dir_y_d;
   logic             paddle_hit_q, paddle_hit_d, miss_q, miss_d, game_over_q, game_over_d;
   logic [1:0]       lives_q, lives_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // 10-bit sums so right/bottom edges near 511 cannot wrap
   logic [9:0] bx10, by10, px10, bx_end, by_end, px_end, park_x;
   logic       hit_right, hit_left, hit_top, hit_paddle, ball_lost, tick;
   logic       ndx, ndy;

   assign bx10   = {1'b0, ball_x_q};
   assign by10   = {1'b0, ball_y_q};
   assign px10   = {1'b0, paddle_x};
   assign bx_end = bx10 + BALL10;
   assign by_end = by10 + BALL10;
   assign px_end = px10 + PW10;
   assign park_x = px10 + PARK_OFF;

   assign hit_right  = dir_x_q && (bx_end >= XMAX10);
   assign hit_left   = !dir_x_q && (bx10 <= XMIN10);
   assign hit_top    = !dir_y_q && (by10 <= YMIN10);
   assign hit_paddle = dir_y_q && (by_end == PY10) && (bx_end > px10) && (bx10 < px_end);
   assign ball_lost  = dir_y_q && (by_end >= YMAX10);
   assign tick       = start && (state_q == MOVE) && (cnt_q == CNT_LAST);

   always_comb begin
      state_d      = state_q;
      ball_x_d     = ball_x_q;
      ball_y_d     = ball_y_q;
      dir_x_d      = dir_x_q;
      dir_y_d      = dir_y_q;
      lives_d      = lives_q;
      cnt_d        = '0;
      paddle_hit_d = 1'b0;
      miss_d       = 1'b0;
      ndx          = dir_x_q;
      ndy          = dir_y_q;
      unique case (state_q)
         PARK: begin
            ball_x_d = park_x[8:0];
            ball_y_d = PARK_Y;
            dir_x_d  = 1'b1;
            dir_y_d  = 1'b0;
            if (start && !serve_n) state_d = MOVE;
         end
         MOVE: begin
            if (!start) begin
               cnt_d = cnt_q;
            end else if (!tick) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else if (ball_lost) begin
               // lost ball stays where it was and keeps its direction
               state_d = MISS;
               miss_d  = 1'b1;
            end else begin
               if (hit_right)     ndx = 1'b0;
               else if (hit_left) ndx = 1'b1;
               if (hit_top) begin
                  ndy = 1'b1;
               end else if (hit_paddle) begin
                  ndy          = 1'b0;
                  paddle_hit_d = 1'b1;
               end
               dir_x_d  = ndx;
               dir_y_d  = ndy;
               ball_x_d = ndx ? ball_x_q + 9'd1 : ball_x_q - 9'd1;
               ball_y_d = ndy ? ball_y_q + 9'd1 : ball_y_q - 9'd1;
            end
         end
         MISS: begin
            lives_d = lives_q - 2'd1;
            state_d = (lives_q <= 2'd1) ? OVER : PARK;
         end
         OVER: begin
            lives_d = 2'd0;
         end
         default: state_d = PARK;
      endcase
      game_over_d = (state_d == OVER);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= PARK;
         ball_x_q     <= RST_X;
         ball_y_q     <= PARK_Y;
         dir_x_q      <= 1'b1;
         dir_y_q      <= 1'b0;
         lives_q      <= 2'(LIVES);
         cnt_q        <= '0;
         paddle_hit_q <= 1'b0;
         miss_q       <= 1'b0;
         game_over_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         ball_x_q     <= ball_x_d;
         ball_y_q     <= ball_y_d;
         dir_x_q      <= dir_x_d;
         dir_y_q      <= dir_y_d;
         lives_q      <= lives_d;
         cnt_q        <= cnt_d;
         paddle_hit_q <= paddle_hit_d;
         miss_q       <= miss_d;
         game_over_q  <= game_over_d;
      end
   end

   assign ball_x     = ball_x_q;
   assign ball_y     = ball_y_q;
   assign dir_x      = dir_x_q;
   assign dir_y      = dir_y_q;
   assign state      = state_q;
   assign paddle_hit = paddle_hit_q;
   assign miss       = miss_q;
   assign lives      = lives_q;
   assign game_over  = game_over_q;

endmodule

// File: tb/tb_ball_motion.sv
// Testbench for ball_motion with a short step period. A playfield model tracks
// the ball tick by tick from the game rules; every cycle's outputs are
// compared against it, plus fixed-value checks at the interesting events.
module tb_ball_motion;
   localparam int STEP = 2;
   localparam int XMIN = 134, XMAX = 506, YMIN = 40, YMAX = 470;
   localparam int PW = 62, PY = 440, PX0 = 290, BS = 8;

   logic       clk = 1'b0, rst = 1'b0, start = 1'b0, serve_n = 1'b1;
   logic [8:0] paddle_x = 9'd290;
   logic [8:0] ball_x, ball_y;
   logic       dir_x, dir_y, paddle_hit, miss, game_over;
   logic [1:0] state, lives;

   int tests = 0, fails = 0;

   // playfield model
   int m_state, m_bx, m_by, m_cnt, m_lives;
   bit m_dx, m_dy, m_hit, m_miss;

   ball_motion #(.STEP_CYCLES(STEP)) dut (
      .clk(clk), .rst(rst), .start(start), .serve_n(serve_n), .paddle_x(paddle_x),
      .ball_x(ball_x), .ball_y(ball_y), .dir_x(dir_x), .dir_y(dir_y), .state(state),
      .paddle_hit(paddle_hit), .miss(miss), .lives(lives), .game_over(game_over));

   always #5 clk = ~clk;

   task automatic model_reset();
      m_state = 0; m_bx = PX0 + PW / 2 - BS / 2; m_by = PY - BS;
      m_dx = 1; m_dy = 0; m_cnt = 0; m_lives = 3; m_hit = 0; m_miss = 0;
   endtask

   task automatic model_tick();
      if (m_dy && m_by + BS >= YMAX) begin
         m_state = 2;
         return;
      end
      if (m_dx && m_bx + BS >= XMAX) m_dx = 0;
      else if (!m_dx && m_bx <= XMIN) m_dx = 1;
      if (!m_dy && m_by <= YMIN) m_dy = 1;
      else if (m_dy && m_by + BS == PY && m_bx + BS > int'(paddle_x) && m_bx < int'(paddle_x) + PW) begin
         m_dy = 0; m_hit = 1;
      end
      m_bx = m_dx ? m_bx + 1 : m_bx - 1;
      m_by = m_dy ? m_by + 1 : m_by - 1;
   endtask

   task automatic model_clock();
      m_hit = 0;
      if (!rst) begin model_reset(); return; end
      case (m_state)
         0: begin
            m_bx = (int'(paddle_x) + PW / 2 - BS / 2) % 512; m_by = PY - BS;
            m_dx = 1; m_dy = 0; m_cnt = 0;
            if (start && !serve_n) m_state = 1;
         end
         1: if (start) begin
            if (m_cnt == STEP - 1) begin m_cnt = 0; model_tick(); end
            else m_cnt++;
         end
         2: begin m_lives--; m_state = (m_lives == 0) ? 3 : 0; end
         default: ;
      endcase
      m_miss = (m_state == 2);
   endtask

   function automatic logic [26:0] exp_vec();
      return {9'(m_bx), 9'(m_by), m_dx, m_dy, 2'(m_state), m_hit, m_miss, 2'(m_lives), (m_state == 3)};
   endfunction

   function automatic logic [26:0] dut_vec();
      return {ball_x, ball_y, dir_x, dir_y, state, paddle_hit, miss, lives, game_over};
   endfunction

   function automatic string fmt(logic [26:0] v);
      return $sformatf("x=%0d y=%0d dx=%0b dy=%0b st=%0d hit=%0b miss=%0b lives=%0d go=%0b",
                       v[26:18], v[17:9], v[8], v[7], v[6:5], v[4], v[3], v[2:1], v[0]);
   endfunction

   task automatic adv();
      @(posedge clk);
      model_clock();
      @(negedge clk);
   endtask

   // Runs with random start/paddle until the ball sits on the paddle row descending.
   task automatic approach_row(input string name, output bit ok);
      ok = 0;
      for (int i = 0; i < 8000 && !ok; i++) begin
         if (m_state == 1 && m_dy && m_by + BS == PY) begin ok = 1; break; end
         start = ($urandom_range(0, 3) != 0);
         if (m_by < 400) paddle_x = 9'($urandom_range(0, 440));
         adv();
         tests++;
         if (dut_vec() !== exp_vec()) begin
            fails++; $display("FAIL %s_track: got %s expected %s", name, fmt(dut_vec()), fmt(exp_vec()));
         end
      end
      if (!ok) begin tests++; fails++; $display("FAIL %s_timeout: got no approach expected approach", name); end
      start = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; serve_n = 1'b1; paddle_x = 9'd290;
      model_reset();
      #12;
      tests++;
      if (dut_vec() !== {9'd317, 9'd432, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd3, 1'b0}) begin
         fails++; $display("FAIL reset_values: got %s expected x=317 y=432 dx=1 dy=0 st=0 lives=3", fmt(dut_vec()));
      end
      @(negedge clk); rst = 1'b1;
      adv();
      tests++;
      if (ball_x !== 9'd317 || ball_y !== 9'd432 || state !== 2'd0) begin
         fails++; $display("FAIL park_290: got x=%0d y=%0d st=%0d expected x=317 y=432 st=0", ball_x, ball_y, state);
      end
      paddle_x = 9'd200;
      adv();
      tests++;
      if (ball_x !== 9'd227 || dut_vec() !== exp_vec()) begin
         fails++; $display("FAIL park_200: got %s expected x=227 (%s)", fmt(dut_vec()), fmt(exp_vec()));
      end
   endtask

   task automatic test_serve_step();
      paddle_x = 9'd290;
      adv();
      start = 1'b1; serve_n = 1'b0;
      adv();
      serve_n = 1'b1;
      tests++;
      if (state !== 2'd1 || ball_x !== 9'd317) begin
         fails++; $display("FAIL serve_state: got st=%0d x=%0d expected st=1 x=317", state, ball_x);
      end
      adv(); adv();
      tests++;
      if (ball_x !== 9'd318 || ball_y !== 9'd431 || dut_vec() !== exp_vec()) begin
         fails++; $display("FAIL first_step: got %s expected x=318 y=431", fmt(dut_vec()));
      end
      adv();
      start = 1'b0;
      repeat (20) adv();
      tests++;
      if (ball_x !== 9'd318 || ball_y !== 9'd431) begin
         fails++; $display("FAIL start_freeze: got x=%0d y=%0d expected x=318 y=431", ball_x, ball_y);
      end
      // the timer held its count, so the tick comes on the first enabled clock
      start = 1'b1;
      adv();
      tests++;
      if (ball_x !== 9'd319 || ball_y !== 9'd430 || dut_vec() !== exp_vec()) begin
         fails++; $display("FAIL timer_hold: got %s expected x=319 y=430", fmt(dut_vec()));
      end
   endtask

   task automatic test_walls();
      bit pdx;
      for (int side = 0; side < 2; side++) begin
         bit seen = 0;
         for (int i = 0; i < 6000 && !seen; i++) begin
            start = ($urandom_range(0, 3) != 0);
            if (m_by < 400) paddle_x = 9'($urandom_range(0, 440));
            pdx = m_dx;
            adv();
            tests++;
            if (dut_vec() !== exp_vec()) begin
               fails++; $display("FAIL walls_track: got %s expected %s", fmt(dut_vec()), fmt(exp_vec()));
            end
            if (side == 0 && pdx && !m_dx) begin
               seen = 1; tests++;
               if (ball_x !== 9'd497 || dir_x !== 1'b0) begin
                  fails++; $display("FAIL right_wall: got x=%0d dx=%0b expected x=497 dx=0", ball_x, dir_x);
               end
            end
            if (side == 1 && !pdx && m_dx) begin
               seen = 1; tests++;
               if (ball_x !== 9'd135 || dir_x !== 1'b1) begin
                  fails++; $display("FAIL left_wall: got x=%0d dx=%0b expected x=135 dx=1", ball_x, dir_x);
               end
            end
         end
         if (!seen) begin tests++; fails++; $display("FAIL wall_timeout: got no bounce expected bounce side %0d", side); end
      end
      start = 1'b1;
   endtask

   task automatic test_paddle();
      bit ok;
      int py;
      approach_row("hit", ok);
      if (ok) begin
         paddle_x = 9'(m_bx + 7);   // one pixel of overlap on the paddle's left edge
         py = m_by;
         for (int i = 0; i < 8 && m_by == py; i++) adv();
         tests++;
         if (paddle_hit !== 1'b1 || dir_y !== 1'b0 || ball_y !== 9'd431 || dut_vec() !== exp_vec()) begin
            fails++; $display("FAIL paddle_hit: got %s expected hit=1 dy=0 y=431", fmt(dut_vec()));
         end
         adv();
         tests++;
         if (paddle_hit !== 1'b0) begin
            fails++; $display("FAIL hit_pulse: got hit=%0b expected hit=0", paddle_hit);
         end
      end
      approach_row("nohit", ok);
      if (ok) begin
         paddle_x = 9'(m_bx + 8);   // touching but not overlapping
         py = m_by;
         for (int i = 0; i < 8 && m_by == py; i++) adv();
         tests++;
         if (paddle_hit !== 1'b0 || dir_y !== 1'b1 || ball_y !== 9'd433 || dut_vec() !== exp_vec()) begin
            fails++; $display("FAIL paddle_miss: got %s expected hit=0 dy=1 y=433", fmt(dut_vec()));
         end
      end
   endtask

   task automatic wait_miss(input string name, output bit ok);
      ok = 0;
      for (int i = 0; i < 400 && !ok; i++) begin
         start = ($urandom_range(0, 3) != 0);
         adv();
         tests++;
         if (dut_vec() !== exp_vec()) begin
            fails++; $display("FAIL %s_track: got %s expected %s", name, fmt(dut_vec()), fmt(exp_vec()));
         end
         if (m_state == 2) ok = 1;
      end
      if (!ok) begin tests++; fails++; $display("FAIL %s_timeout: got no miss expected miss", name); end
      start = 1'b1;
   endtask

   task automatic test_miss_lives();
      bit ok;
      wait_miss("miss1", ok);
      if (ok) begin
         tests++;
         if (miss !== 1'b1 || state !== 2'd2 || ball_y !== 9'd462 || lives !== 2'd3) begin
            fails++; $display("FAIL miss_pulse: got %s expected miss=1 st=2 y=462 lives=3", fmt(dut_vec()));
         end
         adv();
         tests++;
         if (miss !== 1'b0 || lives !== 2'd2 || state !== 2'd0) begin
            fails++; $display("FAIL miss_after: got %s expected miss=0 lives=2 st=0", fmt(dut_vec()));
         end
      end
   endtask

   task automatic test_game_over();
      bit ok;
      int fx, fy;
      for (int k = 0; k < 2; k++) begin
         paddle_x = 9'($urandom_range(100, 400));
         adv();
         start = 1'b1; serve_n = 1'b0;
         adv();
         serve_n = 1'b1;
         approach_row("over_row", ok);
         paddle_x = 9'(m_bx - PW);   // ball just past the paddle's right edge
         wait_miss("over_miss", ok);
         adv();
         tests++;
         if (lives !== 2'(1 - k) || state !== (k == 0 ? 2'd0 : 2'd3) || game_over !== 1'(k)) begin
            fails++; $display("FAIL over_lives%0d: got %s expected lives=%0d", k, fmt(dut_vec()), 1 - k);
         end
      end
      fx = m_bx; fy = m_by;
      serve_n = 1'b0;
      repeat (6) adv();
      serve_n = 1'b1;
      tests++;
      if (state !== 2'd3 || game_over !== 1'b1 || lives !== 2'd0 || ball_x !== 9'(fx) || ball_y !== 9'(fy)) begin
         fails++; $display("FAIL over_sticky: got %s expected st=3 go=1 lives=0 x=%0d y=%0d", fmt(dut_vec()), fx, fy);
      end
      rst = 1'b0;
      model_reset();
      #1;
      tests++;
      if (lives !== 2'd3 || state !== 2'd0 || game_over !== 1'b0 || ball_x !== 9'd317 || ball_y !== 9'd432) begin
         fails++; $display("FAIL over_reset: got %s expected lives=3 st=0 go=0 x=317 y=432", fmt(dut_vec()));
      end
      adv();
      rst = 1'b1;
   endtask

   task automatic test_random();
      for (int i = 0; i < 4000; i++) begin
         start   = ($urandom_range(0, 7) != 0);
         serve_n = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 3) == 0) paddle_x = 9'($urandom_range(0, 511));
         else if (m_state == 1 && m_by >= 420 && $urandom_range(0, 1) == 1)
            paddle_x = 9'((m_bx + 8 - int'($urandom_range(0, 69))) & 511);
         if ((m_state == 3 && $urandom_range(0, 9) == 0) || $urandom_range(0, 999) == 0) begin
            rst = 1'b0;
            model_reset();
            #1;
            tests++;
            if (dut_vec() !== exp_vec()) begin
               fails++; $display("FAIL rand_async_reset: got %s expected %s", fmt(dut_vec()), fmt(exp_vec()));
            end
            adv();
            rst = 1'b1;
         end
         adv();
         tests++;
         if (dut_vec() !== exp_vec()) begin
            fails++; $display("FAIL rand_track: got %s expected %s", fmt(dut_vec()), fmt(exp_vec()));
         end
      end
   endtask

   initial begin
      test_reset();
      test_serve_step();
      test_walls();
      test_paddle();
      test_miss_lives();
      test_game_over();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ball_motion.md
Name: ball_motion

Overview:
- Ball-motion engine for the brick-breaker playfield, and the consumer of the paddle position bus.
- Parks the ball on the paddle until served, then steps it one pixel per axis on each step tick.
- Reflects the ball off the side walls, the top wall and the paddle, and detects misses past the paddle.
- Maintains the lives count and the game-over flag; its position outputs feed the renderer and the brick collision block.

Parameters:
X_MIN, 134, left playfield edge (pixels)
X_MAX, 506, right playfield edge (exclusive)
Y_MIN, 40, top playfield edge
Y_MAX, 470, bottom miss line
PADDLE_W, 62, paddle width
PADDLE_Y, 440, paddle top row
PADDLE_X0, 290, paddle x at reset
BALL_SIZE, 8, ball side length (square)
STEP_CYCLES, 250000, clk cycles per motion step
LIVES, 3, lives at reset (2-bit counter)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  game-run enable; 0 freezes motion and the step timer
serve_n  in  1  serve button, active-low
paddle_x  in  9  paddle left x from the paddle block
ball_x  out  9  ball left x
ball_y  out  9  ball top y
dir_x  out  1  1=right, 0=left
dir_y  out  1  1=down, 0=up
state  out  2  0=PARK, 1=MOVE, 2=MISS, 3=OVER
paddle_hit  out  1  one-cycle pulse on paddle bounce
miss  out  1  one-cycle pulse on ball lost
lives  out  2  remaining lives
game_over  out  1  high in OVER

Behaviour:
- Reset values:
  - state=PARK, lives=LIVES, dir_x=1, dir_y=0, paddle_hit=0, miss=0, game_over=0, step counter=0.
  - ball_x = PADDLE_X0 + PADDLE_W/2 - BALL_SIZE/2 (317 with defaults); ball_y = PADDLE_Y - BALL_SIZE (432).
- Arithmetic: all position sums are computed at 10 bits so that ball_x+BALL_SIZE and paddle_x+PADDLE_W cannot wrap; outputs are 9 bits.
- Step tick:
  - The counter counts while start=1 and state=MOVE.
  - A one-cycle tick fires when the counter reaches STEP_CYCLES-1, and the counter then returns to 0.
  - With start=0 the counter holds its value; it clears on any exit from MOVE.
- PARK:
  - Every clock, ball_x <= paddle_x + PADDLE_W/2 - BALL_SIZE/2 and ball_y <= PADDLE_Y - BALL_SIZE.
  - dir_x=1, dir_y=0.
  - If start=1 and serve_n=0, go to MOVE on the next clock.
- MOVE, on a tick: evaluate collisions at the current position, update directions, then move one pixel along each axis using the new directions.
  - Right wall: dir_x=1 and ball_x+BALL_SIZE >= X_MAX -> dir_x=0.
  - Left wall: dir_x=0 and ball_x <= X_MIN -> dir_x=1.
  - Top wall: dir_y=0 and ball_y <= Y_MIN -> dir_y=1.
  - Paddle bounce: all of the following hold -> dir_y=0 and paddle_hit=1 for one cycle.
    - dir_y=1
    - ball_y+BALL_SIZE == PADDLE_Y
    - ball_x+BALL_SIZE > paddle_x
    - ball_x < paddle_x+PADDLE_W
  - Corner case: when a wall condition and a vertical condition are both true in the same tick, both directions flip in that tick.
  - Miss: dir_y=1 and ball_y+BALL_SIZE >= Y_MAX -> go to MISS; the ball does not move on this tick and is not reflected.
- MISS, exactly one cycle:
  - miss=1 and lives <= lives-1.
  - If the old lives value was 1, go to OVER; otherwise go to PARK.
- OVER:
  - game_over=1; the ball is frozen; lives=0.
  - serve_n is ignored; only reset leaves OVER.
- paddle_x is sampled every clock and needs no handshake. A paddle move between ticks takes effect at the next tick.
- Asserting reset mid-motion returns the block to the reset values immediately (asynchronous reset).

Test Plan:
- Reset then park (STEP_CYCLES=2): assert rst=0, release, drive paddle_x=290 -> ball_x=317, ball_y=432, state=0, lives=3. Then drive paddle_x=200 -> ball_x=227 on the next clock.
- Serve and first step: from PARK with paddle_x=290, start=1, pulse serve_n=0 -> state=1; after the first tick, ball_x=318 and ball_y=431. Drive start=0 for 20 cycles -> position unchanged.
- Right-wall bounce: force ball_x=498, dir_x=1, ball_y=200, dir_y=0 via a serve-and-run sequence -> the next tick gives dir_x=0 and ball_x=497. Also check the left wall at ball_x=134 -> 135.
- Paddle bounce and edge overlap:
  - ball_y=432 descending, ball_x=300, paddle_x=290 -> dir_y=0, ball_y=431, paddle_hit high for exactly 1 cycle.
  - ball_x=221 with paddle_x=290 (no overlap) -> no bounce.
  - ball_x=283 (overlap by 1 pixel) -> bounce.
- Miss and lives: paddle_x=134, ball descending at x=400 -> the ball passes y=432 and, at y=462, miss pulses for 1 cycle, lives goes 3->2 and state returns to 0.
- Game over: two further misses -> lives=0, state=3, game_over=1. Then pulse serve_n=0 -> no change. Then rst=0 -> lives=3 and state=0.
